// File: rtl/irq_pkg.sv
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared types and defaults for the interrupt vector controller.
//            Build option IRQ_RR_PRIO_EN selects round-robin priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  localparam int          c_max_src       = 16;
  localparam logic [31:0] c_vec_base_def  = 32'h0000_0100;
  localparam int          c_vec_shift_def = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    SERVICE = 2'b10
  } irq_state_e;

  // Vector arithmetic is modulo 2^32 so a high base wraps through zero.
  function automatic logic [31:0] irq_vec_addr(input logic [31:0] base,
                                               input logic [31:0] id,
                                               input int          shift);
    return base + (id << shift);
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Combinational rotating priority encoder; the first set request at
//            or after index 'start' (wrapping) wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld
);

  int w_idx;

  // Walk from the lowest-priority slot upward so the last hit is the winner.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    w_idx   = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      w_idx = int'(start) + i;
      if (w_idx >= N_SRC) begin
        w_idx = w_idx - N_SRC;
      end
      if (req[w_idx]) begin
        gnt_id  = ID_W'(w_idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
// ============================================================================
// Module   : irq_vector_ctrl
// Brief    : Edge-captured, masked interrupt controller producing a one-cycle
//            INT pulse and vector entryPoint for the core's PC-select path.
//            Define IRQ_RR_PRIO_EN for round-robin instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_vector_ctrl
  import irq_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] VEC_BASE  = c_vec_base_def,
  parameter int          VEC_SHIFT = c_vec_shift_def
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         irq_src,
  input  logic                     mask_we,
  input  logic [N_SRC-1:0]         mask_wdata,
  input  logic                     eoi,
  output logic                     INT,
  output logic [31:0]              entryPoint,
  output logic [$clog2(N_SRC)-1:0] irq_id,
  output logic                     busy,
  output logic [N_SRC-1:0]         pending
);

  localparam int c_id_w = $clog2(N_SRC);

  irq_state_e        r_state;
  irq_state_e        w_state_nxt;
  logic [N_SRC-1:0]  r_src_prev;
  logic [N_SRC-1:0]  r_pend;
  logic [N_SRC-1:0]  r_mask;
  logic [N_SRC-1:0]  w_edge;
  logic [N_SRC-1:0]  w_req;
  logic [N_SRC-1:0]  w_clr;
  logic [c_id_w-1:0] r_id;
  logic [c_id_w-1:0] w_start;
  logic [c_id_w-1:0] w_gnt_id;
  logic              w_gnt_vld;
  logic              w_take;
  logic [31:0]       r_entry;

  assign w_edge = irq_src & ~r_src_prev;
  assign w_req  = r_pend & r_mask;
  assign w_clr  = w_take ? (N_SRC'(1) << w_gnt_id) : '0;

`ifdef IRQ_RR_PRIO_EN
  logic [c_id_w-1:0] r_last;

  // Reset value makes the very first search begin at source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_id_w'(N_SRC - 1);
    end else if (w_take) begin
      r_last <= w_gnt_id;
    end
  end

  assign w_start = (r_last == c_id_w'(N_SRC - 1)) ? '0 : r_last + 1'b1;
`else
  assign w_start = '0;
`endif

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (c_id_w)
  ) u_prio_enc (
    .req     (w_req),
    .start   (w_start),
    .gnt_id  (w_gnt_id),
    .gnt_vld (w_gnt_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    INT         = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_take      = 1'b1;
          w_state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        INT         = 1'b1;
        busy        = 1'b1;
        w_state_nxt = SERVICE;
      end
      SERVICE: begin
        busy = 1'b1;
        if (eoi) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A fresh edge on the source being granted re-pends it (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_src_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_id       <= '0;
      r_entry    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_src_prev <= irq_src;
      r_pend     <= (r_pend & ~w_clr) | w_edge;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      if (w_take) begin
        r_id    <= w_gnt_id;
        r_entry <= irq_vec_addr(VEC_BASE, 32'(w_gnt_id), VEC_SHIFT);
      end
    end
  end

  assign entryPoint = r_entry;
  assign irq_id     = r_id;
  assign pending    = r_pend;

endmodule

`default_nettype wire
